// File: rtl/sum_seq_pkg.sv
// ============================================================================
// sum_seq_pkg : state encoding and default ALU opcodes for sum_sequencer
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sum_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLR_RD  = 3'd1,
    ST_CLR_IMM = 3'd2,
    ST_CLR_EX  = 3'd3,
    ST_RD      = 3'd4,
    ST_IMM     = 3'd5,
    ST_EX      = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  localparam logic [7:0] OP_AND_DEFAULT = 8'h01;
  localparam logic [7:0] OP_ADD_DEFAULT = 8'h05;

endpackage

`default_nettype wire

// File: rtl/sum_seq_term_ctr.sv
// ============================================================================
// sum_seq_term_ctr : current term / remaining-count registers for the sequencer
// Revision         : 1.0
// ============================================================================
`default_nettype none

module sum_seq_term_ctr #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [DATA_W-1:0] first,
  input  logic [DATA_W-1:0] step,
  input  logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] term,
  output logic              rem_zero,
  output logic              rem_last
);

  logic [DATA_W-1:0] term_q, term_d;
  logic [DATA_W-1:0] rem_q,  rem_d;
  logic [DATA_W-1:0] step_q, step_d;

  always_comb begin
    term_d = term_q;
    rem_d  = rem_q;
    step_d = step_q;
    if (load) begin
      term_d = first;
      rem_d  = count;
      step_d = step;
    end else if (advance) begin
      term_d = term_q + step_q;
      rem_d  = rem_q - DATA_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      term_q <= '0;
      rem_q  <= '0;
      step_q <= '0;
    end else begin
      term_q <= term_d;
      rem_q  <= rem_d;
      step_q <= step_d;
    end
  end

  assign term     = term_q;
  assign rem_zero = (rem_q == '0);
  // rem_last predicts that the decrement about to happen reaches zero
  assign rem_last = (rem_q == DATA_W'(1));

endmodule

`default_nettype wire

// File: rtl/sum_sequencer.sv
// ============================================================================
// sum_sequencer : micro-sequencer that accumulates an arithmetic series into a
//                 register by driving immediate / ALU / register-file controls
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sum_sequencer
  import sum_seq_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter int              NUM_REGS = 16,
  parameter int              SEL_W    = 5,
  parameter int              OP_W     = 8,
  parameter logic [OP_W-1:0] OP_AND   = OP_W'(OP_AND_DEFAULT),
  parameter logic [OP_W-1:0] OP_ADD   = OP_W'(OP_ADD_DEFAULT)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [$clog2(NUM_REGS)-1:0] dest_reg,
  input  logic [DATA_W-1:0]           first,
  input  logic [DATA_W-1:0]           step,
  input  logic [DATA_W-1:0]           count,
  output logic [DATA_W-1:0]           immediate,
  output logic                        imm_control,
  output logic                        buff_en,
  output logic [NUM_REGS-1:0]         enable,
  output logic [SEL_W-1:0]            control1,
  output logic [SEL_W-1:0]            control2,
  output logic [OP_W-1:0]             opcode,
  output logic                        busy,
  output logic                        done
);

  localparam int DEST_W = $clog2(NUM_REGS);

  state_t            state_q, state_d;
  logic [DEST_W-1:0] dest_q,  dest_d;
  logic              load, advance;
  logic [DATA_W-1:0] term;
  logic              rem_zero, rem_last;
  logic [NUM_REGS-1:0] dest_onehot;
  logic [SEL_W-1:0]    dest_sel;

  sum_seq_term_ctr #(.DATA_W(DATA_W)) u_term_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .advance  (advance),
    .first    (first),
    .step     (step),
    .count    (count),
    .term     (term),
    .rem_zero (rem_zero),
    .rem_last (rem_last)
  );

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          load    = 1'b1;
          dest_d  = dest_reg;
          state_d = ST_CLR_RD;
        end
      end
      ST_CLR_RD:  state_d = ST_CLR_IMM;
      ST_CLR_IMM: state_d = ST_CLR_EX;
      ST_CLR_EX:  state_d = rem_zero ? ST_DONE : ST_RD;
      ST_RD:      state_d = ST_IMM;
      ST_IMM:     state_d = ST_EX;
      ST_EX: begin
        advance = 1'b1;
        state_d = rem_last ? ST_DONE : ST_RD;
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // Abort overrides every busy transition and freezes the term counter
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      advance = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  assign dest_onehot = NUM_REGS'(1) << dest_q;
  assign dest_sel    = SEL_W'(dest_q) + SEL_W'(1);
  assign control2    = '0;

  always_comb begin
    immediate   = '0;
    imm_control = 1'b0;
    buff_en     = 1'b0;
    enable      = '0;
    control1    = '0;
    opcode      = '0;
    busy        = (state_q != ST_IDLE);
    done        = 1'b0;
    case (state_q)
      ST_CLR_RD, ST_RD: begin
        enable   = dest_onehot;
        control1 = dest_sel;
      end
      ST_CLR_IMM: imm_control = 1'b1;
      ST_CLR_EX: begin
        imm_control = 1'b1;
        buff_en     = 1'b1;
        enable      = dest_onehot;
        opcode      = OP_AND;
      end
      ST_IMM: begin
        imm_control = 1'b1;
        immediate   = term;
      end
      ST_EX: begin
        imm_control = 1'b1;
        immediate   = term;
        buff_en     = 1'b1;
        enable      = dest_onehot;
        opcode      = OP_ADD;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sum_sequencer.sv
// ============================================================================
// tb_sum_sequencer : scoreboard bench for sum_sequencer
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_sum_sequencer;

  typedef struct packed {
    logic [15:0] imm;
    logic        immc;
    logic        buff;
    logic [15:0] en;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic [7:0]  op;
    logic        busy;
    logic        done;
  } out_t;

  localparam int S_CLR_RD = 0, S_CLR_IMM = 1, S_CLR_EX = 2, S_RD = 3,
                 S_IMM = 4, S_EX = 5, S_DONE = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  dest_reg = '0;
  logic [15:0] first = '0, step = '0, count = '0;
  logic [15:0] immediate;
  logic        imm_control, buff_en, busy, done;
  logic [15:0] enable;
  logic [4:0]  control1, control2;
  logic [7:0]  opcode;

  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  int   start_edge = 0;
  out_t exp_q[$];
  int   lat_q[$];

  sum_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dest_reg(dest_reg), .first(first), .step(step), .count(count),
    .immediate(immediate), .imm_control(imm_control), .buff_en(buff_en),
    .enable(enable), .control1(control1), .control2(control2),
    .opcode(opcode), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic out_t actual();
    return '{imm: immediate, immc: imm_control, buff: buff_en, en: enable,
             c1: control1, c2: control2, op: opcode, busy: busy, done: done};
  endfunction

  function automatic out_t mk(int st, int dest, logic [15:0] t);
    out_t v;
    v = '0;
    v.busy = 1'b1;
    case (st)
      S_CLR_RD, S_RD: begin v.en = 16'(1) << dest; v.c1 = 5'(dest + 1); end
      S_CLR_IMM: v.immc = 1'b1;
      S_CLR_EX: begin v.immc = 1'b1; v.buff = 1'b1; v.en = 16'(1) << dest; v.op = 8'h01; end
      S_IMM: begin v.immc = 1'b1; v.imm = t; end
      S_EX: begin
        v.immc = 1'b1; v.imm = t; v.buff = 1'b1;
        v.en = 16'(1) << dest; v.op = 8'h05;
      end
      S_DONE: v.done = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  // Expected per-cycle output sequence of one run, optionally cut after max_n cycles
  task automatic push_run(int dest, logic [15:0] f, logic [15:0] s, int n, int max_n, int lat);
    out_t seq[$];
    logic [15:0] t;
    seq.push_back(mk(S_CLR_RD, dest, 0));
    seq.push_back(mk(S_CLR_IMM, dest, 0));
    seq.push_back(mk(S_CLR_EX, dest, 0));
    t = f;
    for (int i = 0; i < n; i++) begin
      seq.push_back(mk(S_RD, dest, t));
      seq.push_back(mk(S_IMM, dest, t));
      seq.push_back(mk(S_EX, dest, t));
      t = t + s;
    end
    seq.push_back(mk(S_DONE, dest, 0));
    for (int i = 0; i < seq.size() && (max_n < 0 || i < max_n); i++) exp_q.push_back(seq[i]);
    if (max_n < 0) lat_q.push_back(lat);
  endtask

  task automatic do_start(logic [3:0] d, logic [15:0] f, logic [15:0] s, logic [15:0] n);
    dest_reg = d; first = f; step = s; count = n; start = 1'b1;
    @(posedge clk); #1;
    start_edge = edge_cnt;
    start = 1'b0;
  endtask

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic check_all_zero(string name);
    checks++;
    if (actual() !== out_t'(0)) begin
      failures++;
      $display("FAIL %s: outputs %h expected all zero", name, actual());
    end
  endtask

  task automatic wait_idle(string name, int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !busy) return;
    end
    checks++; failures++;
    $display("FAIL %s: timeout, %0d expected cycles left, busy=%b", name, exp_q.size(), busy);
  endtask

  // Monitor: every busy cycle is a presented output and must match the scoreboard
  always @(negedge clk) begin
    out_t got, want;
    if (!reset && (busy || done)) begin
      got = actual();
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_cycle: outputs %h with no expected entry", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL cycle_outputs: got %h expected %h (edge %0d)", got, want, edge_cnt);
        end
      end
      if (done) begin
        checks++;
        if (lat_q.size() == 0) begin
          failures++;
          $display("FAIL done_latency: done with no latency expected");
        end else begin
          int l;
          l = lat_q.pop_front();
          if (edge_cnt - start_edge != l) begin
            failures++;
            $display("FAIL done_latency: got %0d edges expected %0d", edge_cnt - start_edge, l);
          end
        end
      end
    end
  end

  initial begin
    #1;
    check_all_zero("reset_outputs_async");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_all_zero("idle_after_reset");
    @(posedge clk); #1;

    // first=0 step=1 count=3 dest=0 -> immediates 0,1,2, done 12 edges after start
    push_run(0, 16'h0000, 16'h0001, 3, -1, 12);
    do_start(4'd0, 16'h0000, 16'h0001, 16'd3);
    wait_idle("run_count3", 60);

    // count=0 dest=3 -> clear sequence only, done on edge 3
    push_run(3, 16'h1234, 16'h0001, 0, -1, 3);
    do_start(4'd3, 16'h1234, 16'h0001, 16'd0);
    wait_idle("run_count0", 30);

    // wrap: FFFF then 0000
    push_run(1, 16'hFFFF, 16'h0001, 2, -1, 9);
    do_start(4'd1, 16'hFFFF, 16'h0001, 16'd2);
    wait_idle("run_wrap", 40);

    // dest=5 -> control1=6, enable=0020
    push_run(5, 16'h0010, 16'h0100, 1, -1, 6);
    do_start(4'd5, 16'h0010, 16'h0100, 16'd1);
    wait_idle("run_dest5", 30);

    // abort during the second RD (7th busy cycle)
    push_run(2, 16'h0007, 16'h0002, 3, 7, 0);
    do_start(4'd2, 16'h0007, 16'h0002, 16'd3);
    repeat (6) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check_all_zero("abort_outputs");
    check("abort_queue_drained", 64'(exp_q.size()), 64'(0));

    // abort and start together in IDLE: no run
    dest_reg = 4'd2; count = 16'd1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_wins_busy", 64'(busy), 64'(0));

    push_run(2, 16'h0001, 16'h0001, 2, -1, 9);
    do_start(4'd2, 16'h0001, 16'h0001, 16'd2);
    wait_idle("run_after_abort", 40);

    // start pulsed while busy with other operands: original run completes
    push_run(4, 16'h0002, 16'h0003, 2, -1, 9);
    do_start(4'd4, 16'h0002, 16'h0003, 16'd2);
    repeat (3) @(posedge clk);
    #1;
    dest_reg = 4'd9; first = 16'h0100; step = 16'h0050; count = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("run_start_ignored", 60);

    // asynchronous reset mid-EX
    push_run(6, 16'h0005, 16'h0005, 2, 6, 0);
    do_start(4'd6, 16'h0005, 16'h0005, 16'd2);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check("reached_ex_before_reset", 64'(exp_q.size()), 64'(0));
    #1 reset = 1'b1;
    #1;
    check_all_zero("reset_mid_ex_async");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("busy_after_reset", 64'(busy), 64'(0));
    check_all_zero("outputs_after_reset");
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
